// File: rtl/cp0_reg.sv
// rtl/cp0_reg.sv - CP0 register file (Count/Compare/Status/Cause/EPC/PRId/Config); timer gated by CP0_TIMER_EN
module cp0_reg #(
  parameter logic [31:0] PRID_VALUE   = 32'h004c0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000,
  parameter logic [31:0] STATUS_RST   = 32'h10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_STATUS  = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] ADDR_PRID    = 5'd15;
  localparam logic [4:0] ADDR_CONFIG  = 5'd16;

  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_int;
  logic        exc_valid;
  logic        exc_eret;
  logic [4:0]  exc_code;

  // Map a committed exception type onto its ExcCode; eret is handled separately
  always_comb begin
    exc_valid = 1'b1;
    exc_code  = 5'h00;
    case (excepttype_i)
      32'h0000_0001: exc_code = 5'h00;
      32'h0000_0008: exc_code = 5'h08;
      32'h0000_000a: exc_code = 5'h0a;
      32'h0000_000d: exc_code = 5'h0d;
      32'h0000_000c: exc_code = 5'h0c;
      default:       exc_valid = 1'b0;
    endcase
  end

  assign exc_eret = (excepttype_i == 32'h0000_000e);

  // Status/Cause/EPC: MTC0 first, then exception commit so it wins on the fields it touches
  always_ff @(posedge clk) begin
    if (rst) begin
      status <= STATUS_RST;
      cause  <= 32'h0;
      epc    <= 32'h0;
    end else begin
      cause[15:10] <= int_i;
      if (we_i) begin
        case (waddr_i)
          ADDR_STATUS: status <= data_i;
          ADDR_EPC:    epc    <= data_i;
          ADDR_CAUSE: begin
            cause[9:8]   <= data_i[9:8];
            cause[23:22] <= data_i[23:22];
          end
          default: ;
        endcase
      end
      if (exc_valid) begin
        // A nested exception (EXL already set) keeps the original return address
        if (!status[1]) begin
          epc      <= is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
          cause[31] <= is_in_delayslot_i;
        end
        status[1]  <= 1'b1;
        cause[6:2] <= exc_code;
      end else if (exc_eret) begin
        status[1] <= 1'b0;
      end
    end
  end

`ifdef CP0_TIMER_EN
  // Free-running Count, Compare match and sticky timer interrupt cleared by a Compare write
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 32'h0;
      compare   <= 32'h0;
      timer_int <= 1'b0;
    end else begin
      count <= count + 32'd1;
      if ((compare != 32'h0) && (count == compare)) timer_int <= 1'b1;
      if (we_i && (waddr_i == ADDR_COUNT)) count <= data_i;
      if (we_i && (waddr_i == ADDR_COMPARE)) begin
        compare   <= data_i;
        timer_int <= 1'b0;
      end
    end
  end
`else
  assign count     = 32'h0;
  assign compare   = 32'h0;
  assign timer_int = 1'b0;
`endif

  // Combinational read port; no bypass of a same-cycle write
  always_comb begin
    data_o = 32'h0;
    if (!rst) begin
      case (raddr_i)
        ADDR_COUNT:   data_o = count;
        ADDR_COMPARE: data_o = compare;
        ADDR_STATUS:  data_o = status;
        ADDR_CAUSE:   data_o = cause;
        ADDR_EPC:     data_o = epc;
        ADDR_PRID:    data_o = PRID_VALUE;
        ADDR_CONFIG:  data_o = CONFIG_VALUE;
        default:      data_o = 32'h0;
      endcase
    end
  end

  assign count_o     = count;
  assign compare_o   = compare;
  assign status_o    = status;
  assign cause_o     = cause;
  assign epc_o       = epc;
  assign config_o    = CONFIG_VALUE;
  assign prid_o      = PRID_VALUE;
  assign timer_int_o = timer_int;

endmodule

// File: tb/tb_cp0_reg.sv
// tb/tb_cp0_reg.sv - randomized bench for cp0_reg against a behavioural CP0 model
module tb_cp0_reg;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
  logic        timer_int_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
  logic        m_tint;

  cp0_reg dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .data_i(data_i),
    .raddr_i(raddr_i), .int_i(int_i), .excepttype_i(excepttype_i),
    .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
    .data_o(data_o), .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
    .cause_o(cause_o), .epc_o(epc_o), .config_o(config_o), .prid_o(prid_o),
    .timer_int_o(timer_int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (rst) return 32'h0;
    case (a)
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return m_cause;
      5'd14: return m_epc;
      5'd15: return 32'h004c0102;
      5'd16: return 32'h00008000;
      default: return 32'h0;
    endcase
  endfunction

  // One clock of architectural CP0 behaviour, from the current inputs and model state
  task automatic model_step();
    logic [31:0] n_count, n_compare, n_status, n_cause, n_epc;
    logic        n_tint;
    int          code;
    if (rst) begin
      m_count = 0; m_compare = 0; m_status = 32'h10000000; m_cause = 0; m_epc = 0; m_tint = 0;
      return;
    end
    n_count = m_count; n_compare = m_compare; n_status = m_status;
    n_epc = m_epc; n_tint = m_tint;
`ifdef CP0_TIMER_EN
    n_count = m_count + 1;
    if (we_i && waddr_i == 9) n_count = data_i;
    if (we_i && waddr_i == 11) begin
      n_compare = data_i;
      n_tint = 0;
    end else if (m_compare != 0 && m_count == m_compare) begin
      n_tint = 1;
    end
`endif
    n_cause = (m_cause & ~32'h0000fc00) | (32'(int_i) << 10);
    if (we_i && waddr_i == 12) n_status = data_i;
    if (we_i && waddr_i == 14) n_epc = data_i;
    if (we_i && waddr_i == 13) n_cause = (n_cause & ~32'h00c00300) | (data_i & 32'h00c00300);
    code = -1;
    case (excepttype_i)
      32'h1: code = 0;
      32'h8: code = 8;
      32'ha: code = 10;
      32'hd: code = 13;
      32'hc: code = 12;
      default: code = -1;
    endcase
    if (code >= 0) begin
      if (m_status[1] == 1'b0) begin
        n_epc = is_in_delayslot_i ? current_inst_addr_i - 4 : current_inst_addr_i;
        n_cause[31] = is_in_delayslot_i;
      end
      n_status[1] = 1'b1;
      n_cause[6:2] = code[4:0];
    end else if (excepttype_i == 32'he) begin
      n_status[1] = 1'b0;
    end
    m_count = n_count; m_compare = n_compare; m_status = n_status;
    m_cause = n_cause; m_epc = n_epc; m_tint = n_tint;
  endtask

  task automatic idle();
    rst = 0; we_i = 0; waddr_i = 0; data_i = 0; raddr_i = 0; int_i = 0;
    excepttype_i = 0; current_inst_addr_i = 0; is_in_delayslot_i = 0;
  endtask

  // Inputs are applied after a negedge; check read port, clock, then check all state
  task automatic tick();
    #1;
    check("data_o", data_o, model_read(raddr_i));
    @(posedge clk);
    model_step();
    #1;
    check("count_o", count_o, m_count);
    check("compare_o", compare_o, m_compare);
    check("status_o", status_o, m_status);
    check("cause_o", cause_o, m_cause);
    check("epc_o", epc_o, m_epc);
    check("prid_o", prid_o, 32'h004c0102);
    check("config_o", config_o, 32'h00008000);
    check("timer_int_o", {31'h0, timer_int_o}, {31'h0, m_tint});
    @(negedge clk);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle(); we_i = 1; waddr_i = a; data_i = d; tick(); idle();
  endtask

  task automatic except(input logic [31:0] t, input logic [31:0] pc, input logic ds);
    idle(); excepttype_i = t; current_inst_addr_i = pc; is_in_delayslot_i = ds; tick(); idle();
  endtask

  initial begin
    logic [4:0]  waddr_tab [8];
    logic [31:0] exc_tab [10];
    waddr_tab = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
    exc_tab = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h8, 32'ha, 32'hd, 32'hc, 32'he, 32'h3};
    m_count = 0; m_compare = 0; m_status = 32'h10000000; m_cause = 0; m_epc = 0; m_tint = 0;

    // Reset state
    idle(); rst = 1; raddr_i = 5'd12;
    tick(); tick();
    check("rst_status", status_o, 32'h10000000);
    check("rst_prid", prid_o, 32'h004c0102);
    check("rst_config", config_o, 32'h00008000);
    check("rst_count", count_o, 32'h0);
    check("rst_timer", {31'h0, timer_int_o}, 32'h0);
    idle();

`ifdef CP0_TIMER_EN
    // Count wraps through 2^32
    mtc0(5'd9, 32'hffff_fffe);
    check("cnt_w0", count_o, 32'hffff_fffe);
    tick(); check("cnt_w1", count_o, 32'hffff_ffff);
    tick(); check("cnt_w2", count_o, 32'h0);
    tick(); check("cnt_w3", count_o, 32'h1);

    // Compare match raises a sticky interrupt, a Compare write clears it
    mtc0(5'd9, 32'd9);
    mtc0(5'd11, 32'd20);
    check("cmp_cnt", count_o, 32'd10);
    for (int i = 0; i < 40 && !timer_int_o; i++) tick();
    check("tmr_rise", {31'h0, timer_int_o}, 32'h1);
    check("tmr_cnt", count_o, 32'd21);
    tick(); tick(); tick();
    check("tmr_hold", {31'h0, timer_int_o}, 32'h1);
    mtc0(5'd11, 32'd0);
    check("tmr_clr", {31'h0, timer_int_o}, 32'h0);
`else
    mtc0(5'd9, 32'hffff_fffe);
    tick();
    check("cnt_off", count_o, 32'h0);
    mtc0(5'd11, 32'd20);
    check("cmp_off", compare_o, 32'h0);
`endif

    // Syscall in a delay slot, then eret
    except(32'h8, 32'h100, 1'b1);
    check("exc_epc", epc_o, 32'h0000_00fc);
    check("exc_bd", {31'h0, cause_o[31]}, 32'h1);
    check("exc_exl", {31'h0, status_o[1]}, 32'h1);
    check("exc_code", {27'h0, cause_o[6:2]}, 32'h8);
    except(32'he, 32'h0, 1'b0);
    check("eret_exl", {31'h0, status_o[1]}, 32'h0);
    check("eret_epc", epc_o, 32'h0000_00fc);

    // Nested syscall with EXL=1 and same-cycle MTC0 EPC
    except(32'h8, 32'h200, 1'b0);
    check("nest_bd0", {31'h0, cause_o[31]}, 32'h0);
    idle(); we_i = 1; waddr_i = 5'd14; data_i = 32'h55;
    excepttype_i = 32'h8; current_inst_addr_i = 32'h300; is_in_delayslot_i = 1;
    tick(); idle();
    check("nest_epc", epc_o, 32'h55);
    check("nest_code", {27'h0, cause_o[6:2]}, 32'h8);
    check("nest_bd", {31'h0, cause_o[31]}, 32'h0);

    // Cause write mask with live interrupt lines
    idle(); rst = 1; tick(); idle();
    int_i = 6'b101010; we_i = 1; waddr_i = 5'd13; data_i = 32'hffff_ffff;
    tick(); idle();
    check("cause_mask", cause_o, 32'h00c0_ab00);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      idle();
      rst = ($urandom_range(0, 63) == 0);
      we_i = $urandom_range(0, 1);
      waddr_i = waddr_tab[$urandom_range(0, 7)];
      data_i = $urandom;
      if (waddr_i == 5'd11 && $urandom_range(0, 1)) data_i = m_count + $urandom_range(0, 6);
      if (waddr_i == 5'd11 && $urandom_range(0, 7) == 0) data_i = 0;
      raddr_i = $urandom_range(0, 17);
      int_i = $urandom;
      excepttype_i = exc_tab[$urandom_range(0, 9)];
      current_inst_addr_i = $urandom;
      is_in_delayslot_i = $urandom_range(0, 1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
